// File: rtl/time_param_timer.sv
// Programmable interval store with an integrated countdown timer.
// The selected interval is driven on Value, and it is also the value loaded when a countdown starts.
module time_param_timer #(
  parameter int NUM_INTERVALS = 4,
  parameter int VALUE_WIDTH   = 4,
  parameter logic [NUM_INTERVALS*VALUE_WIDTH-1:0] DEFAULT_VALUES = {4'd4, 4'd2, 4'd3, 4'd6},
  localparam int SEL_W = (NUM_INTERVALS > 1) ? $clog2(NUM_INTERVALS) : 1
) (
  input  logic                   clock,
  input  logic                   Reset_Sync,
  input  logic [SEL_W-1:0]       TP_Selector,
  input  logic [VALUE_WIDTH-1:0] Time_Value,
  input  logic                   Prog_Sync,
  input  logic [SEL_W-1:0]       Interval,
  input  logic                   Start_Timer,
  input  logic                   One_Hz_Enable,
  output logic [VALUE_WIDTH-1:0] Value,
  output logic [VALUE_WIDTH-1:0] Remaining,
  output logic                   Busy,
  output logic                   Expired
);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  logic [VALUE_WIDTH-1:0] r_param [NUM_INTERVALS];
  logic [VALUE_WIDTH-1:0] r_remaining, w_remaining_nxt;
  logic [VALUE_WIDTH-1:0] w_value;
  logic                   w_int_ok;
  logic                   r_expired, w_expired_nxt;
  state_t                 r_state, w_state_nxt;

  // Selector values at or above NUM_INTERVALS match no entry, so they read 0 and cannot start a count.
  always_comb begin
    w_value  = '0;
    w_int_ok = 1'b0;
    for (int i = 0; i < NUM_INTERVALS; i++) begin
      if (Interval == SEL_W'(i)) begin
        w_value  = r_param[i];
        w_int_ok = 1'b1;
      end
    end
  end

  // A programmed value of zero restores the default, so a zero is never stored.
  always_ff @(posedge clock or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      for (int i = 0; i < NUM_INTERVALS; i++)
        r_param[i] <= DEFAULT_VALUES[i*VALUE_WIDTH +: VALUE_WIDTH];
    end else if (Prog_Sync) begin
      for (int i = 0; i < NUM_INTERVALS; i++) begin
        if (TP_Selector == SEL_W'(i))
          r_param[i] <= (Time_Value == '0) ? DEFAULT_VALUES[i*VALUE_WIDTH +: VALUE_WIDTH]
                                            : Time_Value;
      end
    end
  end

  always_ff @(posedge clock or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_expired   <= w_expired_nxt;
    end
  end

  // A valid start takes priority over a tick and reloads from the pre-write register value.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_expired_nxt   = 1'b0;
    if (Start_Timer && w_int_ok) begin
      w_state_nxt     = S_COUNT;
      w_remaining_nxt = w_value;
    end else if (r_state == S_COUNT && One_Hz_Enable) begin
      if (r_remaining > VALUE_WIDTH'(1)) begin
        w_remaining_nxt = r_remaining - VALUE_WIDTH'(1);
      end else begin
        w_remaining_nxt = '0;
        w_state_nxt     = S_IDLE;
        w_expired_nxt   = 1'b1;
      end
    end
  end

  assign Value     = w_value;
  assign Remaining = r_remaining;
  assign Busy      = (r_state == S_COUNT);
  assign Expired   = r_expired;

endmodule

// File: tb/tb_time_param_timer.sv
// Bench for time_param_timer: directed scenarios followed by random traffic.
// All outputs are compared against a behavioural model of the interval store and timer.
module tb_time_param_timer;

  localparam int N  = 4;
  localparam int VW = 4;
  localparam int SW = 2;

  logic          clock = 1'b0;
  logic          Reset_Sync;
  logic [SW-1:0] TP_Selector;
  logic [VW-1:0] Time_Value;
  logic          Prog_Sync;
  logic [SW-1:0] Interval;
  logic          Start_Timer;
  logic          One_Hz_Enable;
  logic [VW-1:0] Value;
  logic [VW-1:0] Remaining;
  logic          Busy;
  logic          Expired;

  int n_cmp = 0;
  int n_bad = 0;

  int def_val [N] = '{6, 3, 2, 4};
  int m_par   [N];
  int m_rem;
  int m_busy;
  int m_exp;

  time_param_timer dut (
    .clock        (clock),
    .Reset_Sync   (Reset_Sync),
    .TP_Selector  (TP_Selector),
    .Time_Value   (Time_Value),
    .Prog_Sync    (Prog_Sync),
    .Interval     (Interval),
    .Start_Timer  (Start_Timer),
    .One_Hz_Enable(One_Hz_Enable),
    .Value        (Value),
    .Remaining    (Remaining),
    .Busy         (Busy),
    .Expired      (Expired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_par[i] = def_val[i];
    m_rem  = 0;
    m_busy = 0;
    m_exp  = 0;
  endtask

  // Model advance for one rising edge, using the inputs currently applied.
  task automatic model_edge();
    int iv, sel;
    iv    = int'(Interval);
    sel   = int'(TP_Selector);
    m_exp = 0;
    if (Start_Timer && iv < N) begin
      m_rem  = m_par[iv];
      m_busy = 1;
    end else if (m_busy == 1 && One_Hz_Enable) begin
      m_rem = m_rem - 1;
      if (m_rem <= 0) begin
        m_rem  = 0;
        m_busy = 0;
        m_exp  = 1;
      end
    end
    if (Prog_Sync && sel < N)
      m_par[sel] = (Time_Value == 0) ? def_val[sel] : int'(Time_Value);
  endtask

  task automatic check_all(input string tag);
    int iv;
    iv = int'(Interval);
    check({tag, ".value"},     int'(Value),     (iv < N) ? m_par[iv] : 0);
    check({tag, ".remaining"}, int'(Remaining), m_rem);
    check({tag, ".busy"},      int'(Busy),      m_busy);
    check({tag, ".expired"},   int'(Expired),   m_exp);
  endtask

  // One clock: edge, model update, sample 1 time unit later, then drop the one-cycle pulses.
  task automatic cyc(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
    Prog_Sync     = 1'b0;
    Start_Timer   = 1'b0;
    One_Hz_Enable = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic prog(input int sel, input int tv);
    TP_Selector = SW'(sel);
    Time_Value  = VW'(tv);
    Prog_Sync   = 1'b1;
    cyc("prog");
  endtask

  initial begin
    Reset_Sync    = 1'b1;
    TP_Selector   = '0;
    Time_Value    = '0;
    Prog_Sync     = 1'b0;
    Interval      = '0;
    Start_Timer   = 1'b0;
    One_Hz_Enable = 1'b0;
    model_reset();
    #12;
    Reset_Sync = 1'b0;

    // Reset state and default sweep
    for (int i = 0; i < N; i++) begin
      Interval = SW'(i);
      #1;
      check("dflt.value", int'(Value), def_val[i]);
    end
    check("rst.busy",    int'(Busy),      0);
    check("rst.expired", int'(Expired),   0);
    check("rst.remain",  int'(Remaining), 0);

    // Programming, including a zero reverting to the default
    Interval = 2'd2;
    prog(2, 9);
    check("prog2.value", int'(Value), 9);
    prog(1, 7);
    prog(1, 0);
    Interval = 2'd1;
    #1;
    check("prog1.revert", int'(Value), 3);

    // Full count of interval 0 with ticks five clocks apart
    Interval    = 2'd0;
    Start_Timer = 1'b1;
    cyc("start0");
    check("start0.rem", int'(Remaining), 6);
    for (int t = 1; t <= 6; t++) begin
      idle(4, "gap");
      One_Hz_Enable = 1'b1;
      cyc("tick");
      check("tick.rem", int'(Remaining), 6 - t);
    end
    check("end.expired", int'(Expired), 1);
    check("end.busy",    int'(Busy),    0);
    cyc("post");
    check("post.expired", int'(Expired), 0);

    // Programming during a count leaves the active count alone
    Start_Timer = 1'b1;
    cyc("start0b");
    for (int t = 0; t < 3; t++) begin One_Hz_Enable = 1'b1; cyc("dn"); end
    check("mid.rem", int'(Remaining), 3);
    prog(0, 12);
    for (int t = 0; t < 3; t++) begin One_Hz_Enable = 1'b1; cyc("dn2"); end
    check("mid.expired", int'(Expired), 1);
    Start_Timer = 1'b1;
    cyc("start12");
    check("start12.rem", int'(Remaining), 12);
    Start_Timer   = 1'b1;
    One_Hz_Enable = 1'b1;
    cyc("start_tick");
    check("start_tick.rem", int'(Remaining), 12);

    // Restart on the terminal tick suppresses Expired
    Interval    = 2'd2;
    Start_Timer = 1'b1;
    prog(2, 1);
    check("restart.pre", int'(Remaining), 9);
    Start_Timer = 1'b1;
    cyc("load1");
    check("load1.rem", int'(Remaining), 1);
    Interval      = 2'd1;
    Start_Timer   = 1'b1;
    One_Hz_Enable = 1'b1;
    cyc("restart");
    check("restart.rem",  int'(Remaining), 3);
    check("restart.busy", int'(Busy),      1);
    check("restart.exp",  int'(Expired),   0);
    cyc("restart2");
    check("restart2.exp", int'(Expired), 0);

    // Asynchronous reset between edges during a count
    prog(3, 9);
    One_Hz_Enable = 1'b1;
    cyc("pre_rst");
    #2;
    Reset_Sync = 1'b1;
    #1;
    model_reset();
    check("arst.rem",  int'(Remaining), 0);
    check("arst.busy", int'(Busy),      0);
    check("arst.exp",  int'(Expired),   0);
    Interval = 2'd3;
    #1;
    check("arst.value3", int'(Value), 4);
    @(negedge clock);
    Reset_Sync = 1'b0;
    cyc("after_rst");

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      Interval      = SW'($urandom_range(N - 1));
      TP_Selector   = SW'($urandom_range(N - 1));
      Time_Value    = VW'($urandom_range(3) == 0 ? 0 : $urandom_range(15));
      Prog_Sync     = ($urandom_range(7) == 0);
      Start_Timer   = ($urandom_range(11) == 0);
      One_Hz_Enable = ($urandom_range(2) == 0);
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
